reload_down_timer: RTL and testbench
====================================

# reload_down_timer

Programmable reloading down-counter that is the counterpart of the team's reloading up-counter: it counts toward zero rather than toward all-ones, and reloads from a stored period register at terminal count. It emits a single-cycle expire pulse on every reload and keeps a saturating count of completed periods. It sits beside the up-counter in the timer/counter library and serves as the periodic tick generator for downstream blocks.

## Interface
- WIDTH, 4: counter, load value and reload register width in bits.
- WRAP_W, 8: width of the completed-period counter.

- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- en_i  in  1  count enable; 0 holds the count.
- load_i  in  1  load strobe; has priority over counting.
- load_val_i  in  WIDTH  period value, captured when load_i=1.
- oneshot_i  in  1  one-shot select; present only with ONESHOT_EN.
- count_o  out  WIDTH  current count.
- expire_o  out  1  one-cycle pulse on terminal-count reload.
- busy_o  out  1  high while in RUN.
- wraps_o  out  WRAP_W  completed periods since last load, saturating.

## Operation
- States: IDLE, RUN, DONE. DONE is reachable only with ONESHOT_EN.
- Reset (reset_n=0 at a posedge) sets: state=IDLE, reload_ff=0, count_o=0, expire_o=0, busy_o=0, wraps_o=0. Reset overrides all other inputs.
- Load (load_i=1, any state): reload_ff<=load_val_i, count_o<=load_val_i, wraps_o<=0, expire_o<=0.
  - load_val_i≠0: state<=RUN.
  - load_val_i=0: state<=IDLE.
- RUN, en_i=1, count_o≠0: count_o<=count_o-1.
- RUN, en_i=1, count_o=0 (terminal count):
  - count_o<=reload_ff, expire_o<=1.
  - wraps_o<=wraps_o+1, saturating at 2^WRAP_W-1.
- RUN, en_i=0: all state is held and expire_o<=0.
- IDLE and DONE: count_o and wraps_o are held, expire_o=0, and en_i is ignored. Only load_i leaves either state.
- busy_o = (state==RUN), registered along with the state.
- The period is reload_ff+1 enabled cycles. reload_ff is never 0 while in RUN.
- Simultaneous load_i and terminal count: the load wins, with no expire and no wraps increment.
- Simultaneous load_i and en_i=0: the load still occurs.
- Decrement is modulo 2^WIDTH. Underflow never happens because 0 always triggers a reload.

## Timing
- All outputs are registered, and no output has a combinational path from any input.
- Load at edge N: count_o=load_val_i and busy_o=1 are visible after edge N.
- Terminal count sampled at edge M: after edge M, count_o=reload_ff and expire_o=1 for exactly that one cycle.
- Example, load 3 then en_i=1 continuously: count_o sequence is 3,2,1,0,3,2,1,0,3. expire_o is high during each cycle where count_o has just returned to 3.
- Reset asserted mid-period takes effect at the next edge, and no expire pulse is produced.

## Configuration
- Macro: RELOAD_DOWN_TIMER_ONESHOT_EN.
- Defined:
  - The oneshot_i port exists.
  - At terminal count with oneshot_i=1: count_o stays 0, expire_o pulses once, wraps_o increments, and state<=DONE (busy_o=0).
  - At terminal count with oneshot_i=0: behaviour is identical to the undefined case.
- Undefined:
  - The port is absent and the DONE state is not implemented.
  - Operation is always periodic.

## Test plan
- **Periodic run:** load 3, en_i=1 for 10 cycles.
  - count_o = 3,2,1,0,3,2,1,0,3,2.
  - expire_o high on cycles 5 and 9.
  - wraps_o ends at 2.
- **Enable hold:** load 2, drop en_i for 3 cycles when count_o=1.
  - count_o holds at 1 and expire_o stays 0.
  - After en_i is restored, the sequence continues 0, 2 with an expire pulse on the 2.
- **Load collision:** with count_o=0 and en_i=1, assert load_i with value 6.
  - count_o=6, expire_o=0, wraps_o=0, busy_o=1.
- **Zero load:** load 0, en_i=1 for 20 cycles.
  - state IDLE, count_o=0, busy_o=0, expire_o never asserts.
- **Reset mid-run and saturation:**
  - Load 1, run 600 cycles: wraps_o saturates at 255.
  - Then reset_n=0 for one edge: every output is 0.
- **One-shot (macro defined):** oneshot_i=1, load 2, en_i=1.
  - count_o = 2,1,0,0,0.
  - expire_o pulses once, busy_o falls with the pulse.
  - A subsequent load of 4 returns the block to RUN.

Source files
------------

// File: rtl/reload_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : reload_down_timer
// Description : Programmable reloading down-counter. Counts toward zero and
//               reloads from a stored period register at terminal count,
//               emitting a one-cycle expire pulse and keeping a saturating
//               count of completed periods.
//               Optional one-shot mode: RELOAD_DOWN_TIMER_ONESHOT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module reload_down_timer #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
`ifdef RELOAD_DOWN_TIMER_ONESHOT_EN
  input  logic              oneshot_i,
`endif
  output logic [WIDTH-1:0]  count_o,
  output logic              expire_o,
  output logic              busy_o,
  output logic [WRAP_W-1:0] wraps_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
`ifdef RELOAD_DOWN_TIMER_ONESHOT_EN
    ,
    S_DONE = 2'd2
`endif
  } state_t;

  localparam logic [WRAP_W-1:0] c_WRAP_MAX = {WRAP_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_reload;
  logic [WIDTH-1:0]  w_reload_nxt;
  logic [WIDTH-1:0]  r_count;
  logic [WIDTH-1:0]  w_count_nxt;
  logic [WRAP_W-1:0] r_wraps;
  logic [WRAP_W-1:0] w_wraps_nxt;
  logic              r_expire;
  logic              w_expire_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_oneshot;

`ifdef RELOAD_DOWN_TIMER_ONESHOT_EN
  assign w_oneshot = oneshot_i;
`else
  assign w_oneshot = 1'b0;
`endif

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_reload <= '0;
      r_count  <= '0;
      r_wraps  <= '0;
      r_expire <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_reload <= w_reload_nxt;
      r_count  <= w_count_nxt;
      r_wraps  <= w_wraps_nxt;
      r_expire <= w_expire_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next-state and next-datapath logic; load beats terminal count.
  always_comb begin
    w_state_nxt  = r_state;
    w_reload_nxt = r_reload;
    w_count_nxt  = r_count;
    w_wraps_nxt  = r_wraps;
    w_expire_nxt = 1'b0;

    if (load_i) begin
      w_reload_nxt = load_val_i;
      w_count_nxt  = load_val_i;
      w_wraps_nxt  = '0;
      // A zero period cannot run: reload_ff is never 0 while in RUN.
      w_state_nxt  = (load_val_i != '0) ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_RUN: begin
          if (en_i) begin
            if (r_count != '0) begin
              w_count_nxt = r_count - 1'b1;
            end else begin
              w_expire_nxt = 1'b1;
              if (r_wraps != c_WRAP_MAX) begin
                w_wraps_nxt = r_wraps + 1'b1;
              end
`ifdef RELOAD_DOWN_TIMER_ONESHOT_EN
              if (w_oneshot) begin
                w_count_nxt = '0;
                w_state_nxt = S_DONE;
              end else begin
                w_count_nxt = r_reload;
              end
`else
              w_count_nxt = r_reload;
`endif
            end
          end
        end
        // IDLE and DONE hold everything until the next load.
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == S_RUN);
  end

  // One-shot select is unused when the feature is compiled out.
  logic w_unused;
  assign w_unused = w_oneshot;

  assign count_o  = r_count;
  assign expire_o = r_expire;
  assign busy_o   = r_busy;
  assign wraps_o  = r_wraps;

endmodule
`default_nettype wire

// File: tb/tb_reload_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reload_down_timer
// Description : Self-checking bench for reload_down_timer. A behavioural
//               model predicts outputs per cycle; predictions are queued
//               when stimulus is driven and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reload_down_timer;

  localparam int WIDTH  = 4;
  localparam int WRAP_W = 8;
`ifdef RELOAD_DOWN_TIMER_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic              en_i;
  logic              load_i;
  logic [WIDTH-1:0]  load_val_i;
  logic              oneshot_i;
  logic [WIDTH-1:0]  count_o;
  logic              expire_o;
  logic              busy_o;
  logic [WRAP_W-1:0] wraps_o;

  reload_down_timer #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_i       (en_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
`ifdef RELOAD_DOWN_TIMER_ONESHOT_EN
    .oneshot_i  (oneshot_i),
`endif
    .count_o    (count_o),
    .expire_o   (expire_o),
    .busy_o     (busy_o),
    .wraps_o    (wraps_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]  count;
    logic              expire;
    logic              busy;
    logic [WRAP_W-1:0] wraps;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int               m_state = 0;   // 0 idle, 1 run, 2 done
  logic [WIDTH-1:0] m_reload = '0;
  logic [WIDTH-1:0] m_count  = '0;
  logic [WRAP_W-1:0] m_wraps = '0;
  logic             m_expire = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_step(input logic rn, input logic en, input logic ld,
                            input logic [WIDTH-1:0] val, input logic os);
    if (!rn) begin
      m_state = 0; m_reload = '0; m_count = '0; m_wraps = '0; m_expire = 1'b0;
    end else if (ld) begin
      m_reload = val; m_count = val; m_wraps = '0; m_expire = 1'b0;
      m_state  = (val != 0) ? 1 : 0;
    end else begin
      m_expire = 1'b0;
      if (m_state == 1 && en) begin
        if (m_count != 0) begin
          m_count = m_count - 1;
        end else begin
          m_expire = 1'b1;
          if (m_wraps != 8'hFF) m_wraps = m_wraps + 1;
          if (ONESHOT && os) begin
            m_count = '0;
            m_state = 2;
          end else begin
            m_count = m_reload;
          end
        end
      end
    end
  endtask

  // Drive one cycle, queue the prediction, compare after the edge.
  task automatic cycle(input logic rn, input logic en, input logic ld,
                       input logic [WIDTH-1:0] val, input logic os);
    exp_t e;
    exp_t g;
    reset_n = rn; en_i = en; load_i = ld; load_val_i = val; oneshot_i = os;
    model_step(rn, en, ld, val, os);
    e.count = m_count; e.expire = m_expire; e.busy = (m_state == 1); e.wraps = m_wraps;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check("count",  32'(count_o),  32'(g.count));
    check("expire", 32'(expire_o), 32'(g.expire));
    check("busy",   32'(busy_o),   32'(g.busy));
    check("wraps",  32'(wraps_o),  32'(g.wraps));
  endtask

  initial begin
    reset_n = 1'b0; en_i = 1'b0; load_i = 1'b0; load_val_i = '0; oneshot_i = 1'b0;

    // Reset, with other inputs active to show reset overrides them
    cycle(1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("rst_count", 32'(count_o), 0);
    check("rst_busy",  32'(busy_o), 0);

    // Periodic run: load 3, then 9 enabled cycles -> 2,1,0,3,2,1,0,3,2
    cycle(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    check("per_load_count", 32'(count_o), 3);
    check("per_load_busy",  32'(busy_o), 1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("per_end_count", 32'(count_o), 2);
    check("per_end_wraps", 32'(wraps_o), 2);

    // Enable hold
    cycle(1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("hold_pre", 32'(count_o), 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check("hold_count", 32'(count_o), 1);
    cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("hold_zero", 32'(count_o), 0);
    cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("hold_reload", 32'(count_o), 2);
    check("hold_expire", 32'(expire_o), 1);

    // Load collision at terminal count
    cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("coll_pre", 32'(count_o), 0);
    cycle(1'b1, 1'b1, 1'b1, 4'd6, 1'b0);
    check("coll_count",  32'(count_o), 6);
    check("coll_expire", 32'(expire_o), 0);
    check("coll_wraps",  32'(wraps_o), 0);
    check("coll_busy",   32'(busy_o), 1);

    // Load with enable low still loads
    cycle(1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
    check("load_en0", 32'(count_o), 9);

    // Zero load
    cycle(1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("zero_busy",  32'(busy_o), 0);
    check("zero_count", 32'(count_o), 0);

    // Saturation then reset mid-run
    cycle(1'b1, 1'b1, 1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 600; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("sat_wraps", 32'(wraps_o), 255);
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    check("rst2_count",  32'(count_o), 0);
    check("rst2_expire", 32'(expire_o), 0);
    check("rst2_busy",   32'(busy_o), 0);
    check("rst2_wraps",  32'(wraps_o), 0);

    // Maximum period wraps through full range
    cycle(1'b1, 1'b1, 1'b1, 4'd15, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

    // Mixed random traffic
    for (int i = 0; i < 400; i++) begin
      logic ld;
      logic en;
      logic [WIDTH-1:0] v;
      ld = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 3) != 0);
      v  = WIDTH'($urandom_range(0, 5));
      cycle(1'b1, en, ld, v, 1'b0);
    end

    if (ONESHOT) begin
      cycle(1'b1, 1'b1, 1'b1, 4'd2, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
      check("os_expire", 32'(expire_o), 1);
      check("os_busy",   32'(busy_o), 0);
      check("os_count",  32'(count_o), 0);
      cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
      check("os_hold_expire", 32'(expire_o), 0);
      cycle(1'b1, 1'b1, 1'b1, 4'd4, 1'b1);
      check("os_reload_busy", 32'(busy_o), 1);
      check("os_reload_count", 32'(count_o), 4);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
